// File: rtl/peaks_readout_bridge.sv
// Host readout bridge: captures peak frames into a latest bank and exposes a host-frozen
// snapshot bank, status, dropped-frame count and interrupt over an 8-bit byte-addressed bus.
module peaks_readout_bridge #(
    parameter int unsigned PEAKS      = 6,
    parameter int unsigned TIME_BYTES = 4,
    parameter int unsigned FREQ_BYTES = 1,
    parameter int unsigned AMPL_BYTES = 3,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [7:0]  MAGIC      = 8'h5A
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           peaks_valid,
    input  logic [8*TIME_BYTES-1:0]        counter_in,
    input  logic [PEAKS*8*FREQ_BYTES-1:0]  freqs_in,
    input  logic [PEAKS*8*AMPL_BYTES-1:0]  ampls_in,
    input  logic                           chipselect,
    input  logic                           write,
    input  logic [ADDR_W-1:0]              address,
    input  logic [7:0]                     writedata,
    output logic [7:0]                     readdata,
    output logic                           irq
);

    localparam int unsigned TW        = 8 * TIME_BYTES;
    localparam int unsigned FW        = 8 * FREQ_BYTES;
    localparam int unsigned AW        = 8 * AMPL_BYTES;
    localparam int unsigned TIME_BASE = 4;
    localparam int unsigned FREQ_BASE = TIME_BASE + TIME_BYTES;
    localparam int unsigned AMPL_BASE = FREQ_BASE + PEAKS * FREQ_BYTES;
    localparam int unsigned MAP_SIZE  = 2 ** ADDR_W;

    logic [TW-1:0]       latest_cnt_q, latest_cnt_d;
    logic [PEAKS*FW-1:0] latest_freqs_q, latest_freqs_d;
    logic [PEAKS*AW-1:0] latest_ampls_q, latest_ampls_d;
    logic [TW-1:0]       snap_cnt_q, snap_cnt_d;
    logic [PEAKS*FW-1:0] snap_freqs_q, snap_freqs_d;
    logic [PEAKS*AW-1:0] snap_ampls_q, snap_ampls_d;
    logic                pending_q, pending_d;
    logic [7:0]          dropped_q, dropped_d;
    logic                auto_q, auto_d;
    logic                irq_en_q, irq_en_d;
    logic                irq_q, irq_d;
    logic [7:0]          readdata_q, readdata_d;

    logic                ctrl_wr;
    logic                snap_cmd;
    logic [7:0]          data_bytes [MAP_SIZE];
    logic                unused_wdata;

    assign unused_wdata = ^writedata[7:3];

    always_comb begin
        ctrl_wr        = chipselect && write && (address == ADDR_W'(2));
        snap_cmd       = ctrl_wr && writedata[0];
        latest_cnt_d   = latest_cnt_q;
        latest_freqs_d = latest_freqs_q;
        latest_ampls_d = latest_ampls_q;
        snap_cnt_d     = snap_cnt_q;
        snap_freqs_d   = snap_freqs_q;
        snap_ampls_d   = snap_ampls_q;
        pending_d      = pending_q;
        dropped_d      = dropped_q;
        auto_d         = auto_q;
        irq_en_d       = irq_en_q;

        if (snap_cmd) begin
            snap_cnt_d   = latest_cnt_q;
            snap_freqs_d = latest_freqs_q;
            snap_ampls_d = latest_ampls_q;
            pending_d    = 1'b0;
            dropped_d    = 8'h00;
        end
        if (ctrl_wr) begin
            auto_d   = writedata[1];
            irq_en_d = writedata[2];
        end
        // Capture uses the mode in force before any concurrent CTRL write.
        if (peaks_valid) begin
            latest_cnt_d   = counter_in;
            latest_freqs_d = freqs_in;
            latest_ampls_d = ampls_in;
            if (auto_q) begin
                snap_cnt_d   = counter_in;
                snap_freqs_d = freqs_in;
                snap_ampls_d = ampls_in;
            end else begin
                pending_d = 1'b1;
                if (pending_q && !snap_cmd && (dropped_q != 8'hFF)) begin
                    dropped_d = dropped_q + 8'd1;
                end
            end
        end
        irq_d = pending_d & irq_en_d;
    end

    // Big-endian byte view of the snapshot bank, indexed directly by bus address.
    always_comb begin
        for (int i = 0; i < MAP_SIZE; i++) begin
            data_bytes[i] = 8'h00;
        end
        for (int b = 0; b < TIME_BYTES; b++) begin
            data_bytes[ADDR_W'(TIME_BASE + b)] = snap_cnt_q[(TIME_BYTES - 1 - b) * 8 +: 8];
        end
        for (int p = 0; p < PEAKS; p++) begin
            for (int k = 0; k < FREQ_BYTES; k++) begin
                data_bytes[ADDR_W'(FREQ_BASE + p * FREQ_BYTES + k)] =
                    snap_freqs_q[p * FW + (FREQ_BYTES - 1 - k) * 8 +: 8];
            end
            for (int k = 0; k < AMPL_BYTES; k++) begin
                data_bytes[ADDR_W'(AMPL_BASE + p * AMPL_BYTES + k)] =
                    snap_ampls_q[p * AW + (AMPL_BYTES - 1 - k) * 8 +: 8];
            end
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && !write) begin
            case (address)
                ADDR_W'(0): readdata_d = {5'b0, irq_en_q, auto_q, pending_q};
                ADDR_W'(1): readdata_d = dropped_q;
                ADDR_W'(2): readdata_d = {5'b0, irq_en_q, auto_q, 1'b0};
                ADDR_W'(3): readdata_d = MAGIC;
                default:    readdata_d = data_bytes[address];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latest_cnt_q   <= '0;
            latest_freqs_q <= '0;
            latest_ampls_q <= '0;
            snap_cnt_q     <= '0;
            snap_freqs_q   <= '0;
            snap_ampls_q   <= '0;
            pending_q      <= 1'b0;
            dropped_q      <= 8'h00;
            auto_q         <= 1'b0;
            irq_en_q       <= 1'b0;
            irq_q          <= 1'b0;
            readdata_q     <= 8'h00;
        end else begin
            latest_cnt_q   <= latest_cnt_d;
            latest_freqs_q <= latest_freqs_d;
            latest_ampls_q <= latest_ampls_d;
            snap_cnt_q     <= snap_cnt_d;
            snap_freqs_q   <= snap_freqs_d;
            snap_ampls_q   <= snap_ampls_d;
            pending_q      <= pending_d;
            dropped_q      <= dropped_d;
            auto_q         <= auto_d;
            irq_en_q       <= irq_en_d;
            irq_q          <= irq_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_peaks_readout_bridge.sv
// Directed bench for peaks_readout_bridge; read expectations are queued at issue and
// checked when readdata becomes valid.
module tb_peaks_readout_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         peaks_valid;
    logic [31:0]  counter_in;
    logic [47:0]  freqs_in;
    logic [143:0] ampls_in;
    logic         chipselect;
    logic         write;
    logic [7:0]   address;
    logic [7:0]   writedata;
    logic [7:0]   readdata;
    logic         irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    peaks_readout_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .peaks_valid (peaks_valid),
        .counter_in  (counter_in),
        .freqs_in    (freqs_in),
        .ampls_in    (ampls_in),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        string      t;
        chipselect = 1'b1;
        write      = 1'b0;
        address    = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        chipselect = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk8(t, readdata, e);
    endtask

    task automatic wr_ctrl(input logic [7:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 8'd2;
        writedata  = data;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic frame(input logic [31:0] cnt, input logic [7:0] f0, input logic [23:0] a0,
                         input logic [7:0] f5, input logic [23:0] a5, input logic snap);
        counter_in      = cnt;
        freqs_in        = '0;
        ampls_in        = '0;
        freqs_in[7:0]   = f0;
        freqs_in[47:40] = f5;
        ampls_in[23:0]  = a0;
        ampls_in[143:120] = a5;
        peaks_valid     = 1'b1;
        if (snap) begin
            chipselect = 1'b1;
            write      = 1'b1;
            address    = 8'd2;
            writedata  = 8'h01;
        end
        tick();
        peaks_valid = 1'b0;
        chipselect  = 1'b0;
        write       = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        peaks_valid = 1'b0;
        counter_in  = '0;
        freqs_in    = '0;
        ampls_in    = '0;
        chipselect  = 1'b0;
        write       = 1'b0;
        address     = '0;
        writedata   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk8("rst_irq", {7'b0, irq}, 8'h00);
        read_chk(8'd0, 8'h00, "rst_status");
        read_chk(8'd1, 8'h00, "rst_dropped");
        read_chk(8'd3, 8'h5A, "rst_id");
        read_chk(8'd4, 8'h00, "rst_data4");

        // Frame A then SNAP
        frame(32'h01020304, 8'h11, 24'hAABBCC, 8'h66, 24'h123456, 1'b0);
        read_chk(8'd0, 8'h01, "a_status_pend");
        read_chk(8'd4, 8'h00, "a_data_before_snap");
        wr_ctrl(8'h01);
        read_chk(8'd4, 8'h01, "a_cnt0");
        read_chk(8'd5, 8'h02, "a_cnt1");
        read_chk(8'd6, 8'h03, "a_cnt2");
        read_chk(8'd7, 8'h04, "a_cnt3");
        read_chk(8'd8, 8'h11, "a_freq0");
        read_chk(8'd13, 8'h66, "a_freq5");
        read_chk(8'd14, 8'hAA, "a_ampl0_b0");
        read_chk(8'd15, 8'hBB, "a_ampl0_b1");
        read_chk(8'd16, 8'hCC, "a_ampl0_b2");
        read_chk(8'd29, 8'h12, "a_ampl5_b0");
        read_chk(8'd31, 8'h56, "a_ampl5_b2");
        read_chk(8'd32, 8'h00, "a_past_end");
        read_chk(8'd0, 8'h00, "a_status_clr");

        // Dropped counting and saturation
        for (int i = 0; i < 3; i++) frame(32'(i), 8'h00, 24'h0, 8'h00, 24'h0, 1'b0);
        read_chk(8'd1, 8'h02, "drop_2");
        read_chk(8'd0, 8'h01, "drop_pend");
        for (int i = 3; i < 300; i++) frame(32'(i), 8'h00, 24'h0, 8'h00, 24'h0, 1'b0);
        read_chk(8'd1, 8'hFF, "drop_sat");
        wr_ctrl(8'h01);
        read_chk(8'd1, 8'h00, "drop_clr");
        read_chk(8'd6, 8'h01, "drop_last_cnt2");
        read_chk(8'd7, 8'h2B, "drop_last_cnt3");

        // SNAP coincident with a new frame
        frame(32'h01020304, 8'h11, 24'hAABBCC, 8'h66, 24'h123456, 1'b0);
        wr_ctrl(8'h01);
        frame(32'hB0B1B2B3, 8'h22, 24'hDDEEFF, 8'h77, 24'h0, 1'b1);
        read_chk(8'd4, 8'h01, "coin_snap_old");
        read_chk(8'd8, 8'h11, "coin_freq_old");
        read_chk(8'd0, 8'h01, "coin_status");
        read_chk(8'd1, 8'h00, "coin_dropped");
        wr_ctrl(8'h01);
        read_chk(8'd4, 8'hB0, "coin_next_b");
        read_chk(8'd16, 8'hFF, "coin_next_ampl");

        // Auto mode
        wr_ctrl(8'h02);
        read_chk(8'd2, 8'h02, "ctrl_rd_auto");
        frame(32'hC0C1C2C3, 8'h33, 24'h0, 8'h00, 24'h0, 1'b0);
        read_chk(8'd4, 8'hC0, "auto_c0");
        read_chk(8'd7, 8'hC3, "auto_c3");
        read_chk(8'd0, 8'h02, "auto_status");

        // Interrupt
        wr_ctrl(8'h04);
        chk8("irq_idle", {7'b0, irq}, 8'h00);
        frame(32'hD0D1D2D3, 8'h44, 24'h0, 8'h00, 24'h0, 1'b0);
        chk8("irq_rise", {7'b0, irq}, 8'h01);
        wr_ctrl(8'h05);
        chk8("irq_fall_snap", {7'b0, irq}, 8'h00);
        read_chk(8'd0, 8'h04, "irq_status");
        read_chk(8'd4, 8'hD0, "irq_data_d");
        frame(32'hE0E1E2E3, 8'h55, 24'h0, 8'h00, 24'h0, 1'b0);
        chk8("irq_rise2", {7'b0, irq}, 8'h01);
        wr_ctrl(8'h00);
        chk8("irq_fall_en", {7'b0, irq}, 8'h00);
        read_chk(8'd0, 8'h01, "irq_pend_kept");

        // Reset overriding a concurrent read and frame
        chipselect  = 1'b1;
        write       = 1'b0;
        address     = 8'd3;
        peaks_valid = 1'b1;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        peaks_valid = 1'b0;
        chipselect  = 1'b0;
        chk8("rst2_readdata", readdata, 8'h00);
        chk8("rst2_irq", {7'b0, irq}, 8'h00);
        read_chk(8'd0, 8'h00, "rst2_status");
        read_chk(8'd1, 8'h00, "rst2_dropped");
        read_chk(8'd4, 8'h00, "rst2_data");
        wr_ctrl(8'h01);
        read_chk(8'd4, 8'h00, "rst2_latest_clr");
        read_chk(8'd200, 8'h00, "oor_200");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
